// File: rtl/sap_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sap_pkg : opcodes, sequencer state encoding, control-word bit indices    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package sap_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_OUT = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  // T-states use their own index as encoding so t_state is just the low bits.
  typedef enum logic [3:0] {
    ST_T0   = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_IDLE = 4'd8,
    ST_HALT = 4'd9
  } state_e;

  localparam logic [2:0] T_IDLE_CODE = 3'd7;

  localparam int CW_W        = 13;
  localparam int CW_PC_OUT   = 12;
  localparam int CW_PC_INC   = 11;
  localparam int CW_PC_LOAD  = 10;
  localparam int CW_MAR_LOAD = 9;
  localparam int CW_RAM_OUT  = 8;
  localparam int CW_IR_LOAD  = 7;
  localparam int CW_IR_OUT   = 6;
  localparam int CW_A_LOAD   = 5;
  localparam int CW_A_OUT    = 4;
  localparam int CW_B_LOAD   = 3;
  localparam int CW_ALU_OUT  = 2;
  localparam int CW_ALU_SUB  = 1;
  localparam int CW_OUT_LOAD = 0;

  function automatic logic [2:0] last_step(input logic [3:0] op);
    case (op)
      OP_LDA:         last_step = 3'd3;
      OP_ADD, OP_SUB: last_step = 3'd4;
      default:        last_step = 3'd2;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sap_microcode_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sap_microcode_rom : (state, opcode, cf, zf) -> control word, comb only   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sap_microcode_rom
  import sap_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  state_e            state,
  input  logic [OPC_W-1:0]  ir_opcode,
  input  logic              cf,
  input  logic              zf,
  output logic [CW_W-1:0]   cw
);

  always_comb begin
    cw = '0;
    case (state)
      ST_T0: begin
        cw[CW_PC_OUT]   = 1'b1;
        cw[CW_MAR_LOAD] = 1'b1;
      end
      ST_T1: begin
        cw[CW_RAM_OUT] = 1'b1;
        cw[CW_IR_LOAD] = 1'b1;
        cw[CW_PC_INC]  = 1'b1;
      end
      ST_T2: begin
        case (ir_opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            cw[CW_IR_OUT]   = 1'b1;
            cw[CW_MAR_LOAD] = 1'b1;
          end
          OP_OUT: begin
            cw[CW_A_OUT]    = 1'b1;
            cw[CW_OUT_LOAD] = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OUT]  = 1'b1;
            cw[CW_PC_LOAD] = 1'b1;
          end
          OP_JZ: begin
            cw[CW_IR_OUT]  = zf;
            cw[CW_PC_LOAD] = zf;
          end
          OP_JC: begin
            cw[CW_IR_OUT]  = cf;
            cw[CW_PC_LOAD] = cf;
          end
          OP_NOP, OP_HLT: cw = '0;
          default:        cw = '0;
        endcase
      end
      ST_T3: begin
        case (ir_opcode)
          OP_LDA: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_A_LOAD]  = 1'b1;
          end
          OP_ADD: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_B_LOAD]  = 1'b1;
          end
          // sub select raised a cycle early so the ALU result settles by T4
          OP_SUB: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_B_LOAD]  = 1'b1;
            cw[CW_ALU_SUB] = 1'b1;
          end
          default: cw = '0;
        endcase
      end
      ST_T4: begin
        case (ir_opcode)
          OP_ADD: begin
            cw[CW_ALU_OUT] = 1'b1;
            cw[CW_A_LOAD]  = 1'b1;
          end
          OP_SUB: begin
            cw[CW_ALU_OUT] = 1'b1;
            cw[CW_A_LOAD]  = 1'b1;
            cw[CW_ALU_SUB] = 1'b1;
          end
          default: cw = '0;
        endcase
      end
      default: cw = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sap_control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sap_control_sequencer : T-state ring + run gating; SAP_EARLY_END_EN      |
// | ends each instruction after its last active microstep. rev 1.0           |
// +--------------------------------------------------------------------------+
module sap_control_sequencer
  import sap_pkg::*;
#(
  parameter int OPC_W    = 4,
  parameter int T_STATES = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic             cf,
  input  logic             zf,
  output logic             pc_out,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             mar_load,
  output logic             ram_out,
  output logic             ir_load,
  output logic             ir_out,
  output logic             a_load,
  output logic             a_out,
  output logic             b_load,
  output logic             alu_out,
  output logic             alu_sub,
  output logic             out_load,
  output logic             halted,
  output logic [2:0]       t_state
);

`ifdef SAP_EARLY_END_EN
  localparam bit EARLY_END = 1'b1;
`else
  localparam bit EARLY_END = 1'b0;
`endif

  state_e            state;
  state_e            state_next;
  logic [CW_W-1:0]   rom_cw;
  logic [CW_W-1:0]   cw;
  logic              in_t;
  logic [2:0]        t_idx;

  assign in_t  = (state != ST_IDLE) && (state != ST_HALT);
  assign t_idx = state[2:0];

  sap_microcode_rom #(
    .OPC_W (OPC_W)
  ) u_rom (
    .state     (state),
    .ir_opcode (ir_opcode),
    .cf        (cf),
    .zf        (zf),
    .cw        (rom_cw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cw         = '0;
    case (state)
      ST_IDLE: if (run) state_next = ST_T0;
      ST_HALT: state_next = ST_HALT;
      default: begin
        if (run) begin
          cw = rom_cw;
          if (t_idx == 3'd2 && ir_opcode == OP_HLT)
            state_next = ST_HALT;
          else if (EARLY_END && t_idx == last_step(ir_opcode))
            state_next = ST_T0;
          else if (t_idx == 3'(T_STATES - 1))
            state_next = ST_T0;
          else
            state_next = state_e'(state + 4'd1);
        end
      end
    endcase
  end

  assign pc_out   = cw[CW_PC_OUT];
  assign pc_inc   = cw[CW_PC_INC];
  assign pc_load  = cw[CW_PC_LOAD];
  assign mar_load = cw[CW_MAR_LOAD];
  assign ram_out  = cw[CW_RAM_OUT];
  assign ir_load  = cw[CW_IR_LOAD];
  assign ir_out   = cw[CW_IR_OUT];
  assign a_load   = cw[CW_A_LOAD];
  assign a_out    = cw[CW_A_OUT];
  assign b_load   = cw[CW_B_LOAD];
  assign alu_out  = cw[CW_ALU_OUT];
  assign alu_sub  = cw[CW_ALU_SUB];
  assign out_load = cw[CW_OUT_LOAD];
  assign halted   = (state == ST_HALT);
  assign t_state  = in_t ? t_idx : T_IDLE_CODE;

endmodule
`default_nettype wire

// File: tb/tb_sap_control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sap_control_sequencer : directed checks of control word and T-ring    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sap_control_sequencer;

  localparam logic [12:0] PC_OUT   = 13'h1000;
  localparam logic [12:0] PC_INC   = 13'h0800;
  localparam logic [12:0] PC_LOAD  = 13'h0400;
  localparam logic [12:0] MAR_LOAD = 13'h0200;
  localparam logic [12:0] RAM_OUT  = 13'h0100;
  localparam logic [12:0] IR_LOAD  = 13'h0080;
  localparam logic [12:0] IR_OUT   = 13'h0040;
  localparam logic [12:0] A_LOAD   = 13'h0020;
  localparam logic [12:0] A_OUT    = 13'h0010;
  localparam logic [12:0] B_LOAD   = 13'h0008;
  localparam logic [12:0] ALU_OUT  = 13'h0004;
  localparam logic [12:0] ALU_SUB  = 13'h0002;
  localparam logic [12:0] OUT_LOAD = 13'h0001;
  localparam logic [12:0] FETCH0   = PC_OUT | MAR_LOAD;
  localparam logic [12:0] FETCH1   = RAM_OUT | IR_LOAD | PC_INC;

  logic       clk = 1'b0;
  logic       rst_n, run, cf, zf;
  logic [3:0] ir_opcode;
  logic       pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out;
  logic       a_load, a_out, b_load, alu_out, alu_sub, out_load, halted;
  logic [2:0] t_state;
  logic [12:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sap_control_sequencer dut (
    .clk (clk), .rst_n (rst_n), .run (run), .ir_opcode (ir_opcode),
    .cf (cf), .zf (zf),
    .pc_out (pc_out), .pc_inc (pc_inc), .pc_load (pc_load),
    .mar_load (mar_load), .ram_out (ram_out), .ir_load (ir_load),
    .ir_out (ir_out), .a_load (a_load), .a_out (a_out), .b_load (b_load),
    .alu_out (alu_out), .alu_sub (alu_sub), .out_load (out_load),
    .halted (halted), .t_state (t_state)
  );

  assign obs = {pc_out, pc_inc, pc_load, mar_load, ram_out, ir_load, ir_out,
                a_load, a_out, b_load, alu_out, alu_sub, out_load};

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [12:0] ecw,
                     input logic [2:0] et, input logic eh);
    #1;
    n_cmp++;
    assert (obs === ecw && t_state === et && halted === eh) else begin
      n_err++;
      $error("FAIL %s: got cw=%b t=%0d halted=%b, want cw=%b t=%0d halted=%b",
             tag, obs, t_state, halted, ecw, et, eh);
    end
  endtask

  task automatic to_t0();
    for (int i = 0; i < 10 && t_state !== 3'd0; i++) tick();
    n_cmp++;
    assert (t_state === 3'd0) else begin
      n_err++;
      $error("FAIL to_t0: got t=%0d, want 0 within 10 cycles", t_state);
    end
  endtask

  // bus-driver exclusivity, checked every cycle outside reset
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_cmp++;
      assert ($countones({pc_out, ram_out, ir_out, a_out, alu_out}) <= 1) else begin
        n_err++;
        $error("FAIL bus_onehot: got drivers=%b, want at most one set",
               {pc_out, ram_out, ir_out, a_out, alu_out});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; run = 1'b0; ir_opcode = 4'h0; cf = 1'b0; zf = 1'b0;
    #12;
    chk("reset", '0, 3'd7, 1'b0);
    tick();
    rst_n = 1'b1;
    chk("idle", '0, 3'd7, 1'b0);
    ir_opcode = 4'h1; run = 1'b1;
    chk("idle_run", '0, 3'd7, 1'b0);

    // LDA
    tick(); chk("lda_t0", FETCH0, 3'd0, 1'b0);
    tick(); chk("lda_t1", FETCH1, 3'd1, 1'b0);
    tick(); chk("lda_t2", IR_OUT | MAR_LOAD, 3'd2, 1'b0);
    tick(); chk("lda_t3", RAM_OUT | A_LOAD, 3'd3, 1'b0);
`ifndef SAP_EARLY_END_EN
    tick(); chk("lda_t4", '0, 3'd4, 1'b0);
    tick(); chk("lda_t5", '0, 3'd5, 1'b0);
`endif
    tick(); chk("lda_wrap", FETCH0, 3'd0, 1'b0);

    // SUB
    ir_opcode = 4'h3;
    tick(); chk("sub_t1", FETCH1, 3'd1, 1'b0);
    tick(); chk("sub_t2", IR_OUT | MAR_LOAD, 3'd2, 1'b0);
    tick(); chk("sub_t3", RAM_OUT | B_LOAD | ALU_SUB, 3'd3, 1'b0);
    tick(); chk("sub_t4", ALU_OUT | A_LOAD | ALU_SUB, 3'd4, 1'b0);
`ifndef SAP_EARLY_END_EN
    tick(); chk("sub_t5", '0, 3'd5, 1'b0);
`endif
    tick(); chk("sub_wrap", FETCH0, 3'd0, 1'b0);

    // JZ
    ir_opcode = 4'h6; zf = 1'b1; cf = 1'b0;
    tick(); tick(); chk("jz_taken", IR_OUT | PC_LOAD, 3'd2, 1'b0);
    zf = 1'b0;
    chk("jz_not_taken", '0, 3'd2, 1'b0);
    to_t0();

    // JC
    ir_opcode = 4'h7; cf = 1'b1; zf = 1'b0;
    tick(); tick(); chk("jc_taken", IR_OUT | PC_LOAD, 3'd2, 1'b0);
    cf = 1'b0; zf = 1'b1;
    chk("jc_not_taken", '0, 3'd2, 1'b0);
    to_t0();

    // OUT
    ir_opcode = 4'h4;
    tick(); tick(); chk("out_t2", A_OUT | OUT_LOAD, 3'd2, 1'b0);
    to_t0();

    // ADD with a 4-cycle pause in T3
    ir_opcode = 4'h2;
    tick(); tick(); chk("add_t2", IR_OUT | MAR_LOAD, 3'd2, 1'b0);
    tick(); chk("add_t3", RAM_OUT | B_LOAD, 3'd3, 1'b0);
    run = 1'b0;
    chk("pause_now", '0, 3'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); chk("pause_hold", '0, 3'd3, 1'b0);
    end
    run = 1'b1;
    chk("resume_t3", RAM_OUT | B_LOAD, 3'd3, 1'b0);
    tick(); chk("add_t4", ALU_OUT | A_LOAD, 3'd4, 1'b0);
    to_t0();

    // HLT
    ir_opcode = 4'hF;
    tick(); tick(); chk("hlt_t2", '0, 3'd2, 1'b0);
    tick(); chk("halt_entry", '0, 3'd7, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run = i[0];
      tick(); chk("halt_stay", '0, 3'd7, 1'b1);
    end
    rst_n = 1'b0;
    chk("halt_reset", '0, 3'd7, 1'b0);
    rst_n = 1'b1; run = 1'b0;
    tick(); chk("post_halt_idle", '0, 3'd7, 1'b0);

    // async reset in the middle of T1
    ir_opcode = 4'h1; run = 1'b1;
    tick(); chk("ar_t0", FETCH0, 3'd0, 1'b0);
    tick(); chk("ar_t1", FETCH1, 3'd1, 1'b0);
    #1 rst_n = 1'b0;
    chk("async_reset", '0, 3'd7, 1'b0);
    tick();
    rst_n = 1'b1;

    // random traffic, bus exclusivity checked by the negedge monitor
    for (int i = 0; i < 10000; i++) begin
      run       = ($urandom_range(0, 3) != 0);
      ir_opcode = 4'($urandom_range(0, 14));
      cf        = 1'($urandom);
      zf        = 1'($urandom);
      tick();
    end
    chk("random_not_halted", obs, t_state, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sap_control_sequencer.md
Name: sap_control_sequencer

Overview:
- Fetch/decode/execute controller for the 8-bit bus CPU: accumulator, B register, add/sub unit, PC, MAR, RAM, IR and output register share one tri-state bus.
- A T-state ring (T0..T5) plus opcode and registered flags produce the per-cycle control word: bus-driver enables, register loads and the ALU sub select.
- Guarantees at most one bus driver per cycle.

Parameters:
- OPC_W, 4, opcode width (IR[7:4]).
- T_STATES, 6, T-states per instruction without early end; legal 5..8.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = advance one T-state per cycle; 0 = pause.
- ir_opcode  in  OPC_W  opcode field of the instruction register.
- cf  in  1  carry flag from the add/sub unit, already registered.
- zf  in  1  zero flag from the add/sub unit, already registered.
- pc_out, pc_inc, pc_load  out  1 each  program counter drive, increment and load.
- mar_load, ram_out  out  1 each  MAR load; RAM drives bus.
- ir_load, ir_out  out  1 each  IR load; IR operand nibble drives bus.
- a_load, a_out  out  1 each  accumulator load and drive.
- b_load  out  1  B register load.
- alu_out, alu_sub  out  1 each  ALU drives bus; 1 = subtract.
- out_load  out  1  output register load.
- halted  out  1  in HALT state.
- t_state  out  3  current T index; 7 in IDLE or HALT.

Behaviour:
- States: IDLE, T0..T(T_STATES-1), HALT. Register encoding; control word decoded combinationally from state and ir_opcode.
- Reset (rst_n=0, async): state=IDLE, all controls 0, halted=0, t_state=7.
- IDLE: controls 0. run=1 -> T0 on the next edge.
- run=0 in any Tn: hold state, force every control output to 0; resume at the same Tn when run returns to 1.
- Advance: Tn -> Tn+1. T(T_STATES-1) -> T0.
- Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 OUT, 5 JMP, 6 JZ, 7 JC, F HLT. 8..E behave as NOP.
- Fetch, all opcodes:
  - T0: pc_out, mar_load.
  - T1: ram_out, ir_load, pc_inc.
- T2:
  - LDA/ADD/SUB: ir_out, mar_load.
  - OUT: a_out, out_load.
  - JMP: ir_out, pc_load.
  - JZ: ir_out, pc_load only if zf=1; otherwise controls 0.
  - JC: ir_out, pc_load only if cf=1; otherwise controls 0.
  - HLT: next state HALT.
- T3:
  - LDA: ram_out, a_load.
  - ADD/SUB: ram_out, b_load.
- T4:
  - ADD: alu_out, a_load.
  - SUB: alu_out, a_load, alu_sub.
  - alu_sub is also asserted in T3 for SUB so the operand settles before T4.
- All other opcode/T combinations: controls 0.
- JZ/JC sample zf/cf combinationally in T2. Flags are those produced by the last ADD/SUB T4 edge.
- HALT: halted=1, controls 0, ignores run. Exits only on reset.
- Invariant: at most one of pc_out, ram_out, ir_out, a_out, alu_out is high in any cycle. Verify with an assertion.
- Reset mid-instruction: immediate return to IDLE; no partial load is issued after rst_n falls.

Optional Feature:
- SAP_EARLY_END_EN defined: after an instruction's last active microstep, the next state is T0 instead of padding to T(T_STATES-1).
  - Last active microstep: T2 for NOP, OUT, JMP, JZ, JC and opcodes 8..E; T3 for LDA; T4 for ADD/SUB.
  - NOP therefore takes 3 cycles.
- Undefined: fixed T_STATES cycles per instruction.

Decomposition:
- sap_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - state encoding, including the IDLE/HALT t_state code 7;
  - the control-word bit index constants.
- Sub-module sap_microcode_rom: combinational (state, ir_opcode, cf, zf) -> control word. The top holds the state register, the run gating and the next-state logic.

Test Plan:
- Reset then run=1, opcode=1 (LDA): T0 pc_out+mar_load; T1 ram_out+ir_load+pc_inc; T2 ir_out+mar_load; T3 ram_out+a_load; T4/T5 all 0; back to T0 on the 7th cycle after IDLE.
- opcode=3 (SUB): alu_sub high in T3 and T4; T4 alu_out+a_load. With SAP_EARLY_END_EN, T0 follows T4 (5 cycles per instruction).
- opcode=6 (JZ): zf=1 -> pc_load+ir_out in T2; zf=0 -> T2 controls all 0. Repeat with opcode=7 (JC) and cf.
- opcode=F (HLT): halted=1 from the cycle after T2, t_state=7, controls stay 0 for 20 cycles with run toggling; rst_n pulse -> IDLE, halted=0.
- run dropped in T3 of ADD for 4 cycles: controls 0 and t_state=3 held; on resume T3 ram_out+b_load, then T4.
- rst_n asserted asynchronously mid-T1: outputs 0 before the next clk edge; random opcodes over 10k cycles never drive two bus sources at once.
